// File: rtl/wb_regfile.sv
// Write-back select, 32-entry register file with two combinational read ports,
// and a committed-write counter. Define WB_BYPASS_EN for write-first read ports.
module wb_regfile #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MW_MemtoReg,
    input  logic              MW_RegWrite,
    input  logic [4:0]        MW_RD,
    input  logic [DATA_W-1:0] MW_Result,
    input  logic [DATA_W-1:0] MW_Read_Data,
    input  logic [4:0]        RS1,
    input  logic [4:0]        RS2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] WB_Data,
    output logic [CNT_W-1:0]  WB_Count
);

    // x0 has no storage; reads of index 0 are forced to zero below.
    logic [DATA_W-1:0] regs [1:31];
    logic [CNT_W-1:0]  count_q;
    logic              commit;

    assign WB_Data  = MW_MemtoReg ? MW_Read_Data : MW_Result;
    assign commit   = MW_RegWrite && (MW_RD != 5'd0);
    assign WB_Count = count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
            count_q <= '0;
        end else if (commit) begin
            regs[MW_RD] <= WB_Data;
            count_q     <= count_q + 1'b1;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [4:0] idx);
        logic [DATA_W-1:0] val;
        val = '0;
        if (reset || idx == 5'd0) begin
            val = '0;
`ifdef WB_BYPASS_EN
        end else if (commit && idx == MW_RD) begin
            val = WB_Data;
`endif
        end else begin
            val = regs[idx];
        end
        return val;
    endfunction

    always_comb begin
        ReadData1 = read_port(RS1);
        ReadData2 = read_port(RS2);
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: vector table plus hand-written sequences for
// same-cycle read, reset timing and counter wrap (built with a 4-bit counter).
module tb_wb_regfile;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              reset;
    logic              MW_MemtoReg;
    logic              MW_RegWrite;
    logic [4:0]        MW_RD;
    logic [DATA_W-1:0] MW_Result;
    logic [DATA_W-1:0] MW_Read_Data;
    logic [4:0]        RS1;
    logic [4:0]        RS2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic [DATA_W-1:0] WB_Data;
    logic [CNT_W-1:0]  WB_Count;

    int n_tests;
    int n_fail;
    logic [DATA_W-1:0] exp_q[$];

    wb_regfile #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .MW_MemtoReg  (MW_MemtoReg),
        .MW_RegWrite  (MW_RegWrite),
        .MW_RD        (MW_RD),
        .MW_Result    (MW_Result),
        .MW_Read_Data (MW_Read_Data),
        .RS1          (RS1),
        .RS2          (RS2),
        .ReadData1    (ReadData1),
        .ReadData2    (ReadData2),
        .WB_Data      (WB_Data),
        .WB_Count     (WB_Count)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mtr;
        logic        we;
        logic [4:0]  rd;
        logic [63:0] res;
        logic [63:0] rdd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] e_wb;
        logic [63:0] e_r1;
        logic [63:0] e_r2;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mtr, input logic we, input logic [4:0] rd,
                         input logic [63:0] res, input logic [63:0] rdd,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        MW_MemtoReg  = mtr;
        MW_RegWrite  = we;
        MW_RD        = rd;
        MW_Result    = res;
        MW_Read_Data = rdd;
        RS1          = rs1;
        RS2          = rs2;
    endtask

    initial begin
        logic [3:0]  model_cnt;
        logic [63:0] exp_v;
        logic [4:0]  wr_rd;
        logic        saw_wrap;

        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        drive(1'b0, 1'b0, 5'd0, '0, '0, 5'd0, 5'd0);

        // Each row: inputs driven after a falling edge, outputs checked before the
        // next rising edge, so read ports show the state committed by earlier rows.
        vecs[0] = '{1'b0, 1'b1, 5'd3,  64'hA5, 64'h5A, 5'd0,  5'd0,  64'hA5, 64'h0,  64'h0,  4'd0};
        vecs[1] = '{1'b1, 1'b1, 5'd4,  64'hA5, 64'h5A, 5'd3,  5'd3,  64'h5A, 64'hA5, 64'hA5, 4'd1};
        vecs[2] = '{1'b0, 1'b0, 5'd7,  64'h99, 64'h0,  5'd4,  5'd7,  64'h99, 64'h5A, 64'h0,  4'd2};
        vecs[3] = '{1'b0, 1'b0, 5'd7,  64'h99, 64'h0,  5'd4,  5'd7,  64'h99, 64'h5A, 64'h0,  4'd2};
        vecs[4] = '{1'b0, 1'b0, 5'd7,  64'h99, 64'h0,  5'd4,  5'd7,  64'h99, 64'h5A, 64'h0,  4'd2};
        vecs[5] = '{1'b0, 1'b1, 5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 5'd7, 5'd0,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 4'd2};
        vecs[6] = '{1'b0, 1'b0, 5'd0,  64'h1234, 64'h0, 5'd0, 5'd3,  64'h1234, 64'h0, 64'hA5, 4'd2};
        vecs[7] = '{1'b1, 1'b1, 5'd31, 64'h0, 64'h0123_4567_89AB_CDEF, 5'd4, 5'd4,
                    64'h0123_4567_89AB_CDEF, 64'h5A, 64'h5A, 4'd2};
        vecs[8] = '{1'b0, 1'b0, 5'd5,  64'h0, 64'h0, 5'd31, 5'd3,
                    64'h0, 64'h0123_4567_89AB_CDEF, 64'hA5, 4'd3};

        // reset state
        repeat (2) @(negedge clk);
        drive(1'b0, 1'b1, 5'd2, 64'h11, 64'h22, 5'd2, 5'd2);
        #1;
        check("reset_rd1", ReadData1, 64'h0);
        check("reset_rd2", ReadData2, 64'h0);
        check("reset_cnt", {60'h0, WB_Count}, 64'h0);
        check("reset_wb_mux", WB_Data, 64'h11);
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, '0, '0, 5'd2, 5'd0);
        #1;
        check("reset_write_dropped", ReadData1, 64'h0);
        reset = 1'b0;

        // vector table
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(vecs[i].mtr, vecs[i].we, vecs[i].rd, vecs[i].res, vecs[i].rdd,
                  vecs[i].rs1, vecs[i].rs2);
            #1;
            check($sformatf("vec%0d_wb", i),  WB_Data,   vecs[i].e_wb);
            check($sformatf("vec%0d_rd1", i), ReadData1, vecs[i].e_r1);
            check($sformatf("vec%0d_rd2", i), ReadData2, vecs[i].e_r2);
            check($sformatf("vec%0d_cnt", i), {60'h0, WB_Count}, {60'h0, vecs[i].e_cnt});
        end

        // same-cycle read of the register being written
        @(negedge clk);
        drive(1'b0, 1'b1, 5'd10, 64'hDEAD, 64'h0, 5'd10, 5'd0);
        #1;
`ifdef WB_BYPASS_EN
        check("same_cycle_rd1", ReadData1, 64'hDEAD);
`else
        check("same_cycle_rd1", ReadData1, 64'h0);
`endif
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, '0, '0, 5'd10, 5'd10);
        #1;
        check("next_cycle_rd1", ReadData1, 64'hDEAD);
        check("next_cycle_rd2", ReadData2, 64'hDEAD);
        check("next_cycle_cnt", {60'h0, WB_Count}, 64'd4);

        // asynchronous reset mid-cycle after writing x5
        @(negedge clk);
        drive(1'b0, 1'b1, 5'd5, 64'h1234, 64'h0, 5'd0, 5'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd0, 64'h1, 64'h2, 5'd5, 5'd5);
        #1;
        check("x5_before_reset", ReadData1, 64'h1234);
        check("cnt_before_reset", {60'h0, WB_Count}, 64'd5);
        #1 reset = 1'b1;
        #1;
        check("async_reset_rd1", ReadData1, 64'h0);
        check("async_reset_cnt", {60'h0, WB_Count}, 64'h0);
        check("async_reset_wb_mux", WB_Data, 64'h2);
        @(negedge clk);
        reset = 1'b0;

        // reset coincident with a committing edge
        drive(1'b0, 1'b1, 5'd4, 64'h77, 64'h0, 5'd0, 5'd0);
        @(posedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, 5'd0, '0, '0, 5'd4, 5'd4);
        #1;
        check("edge_reset_x4", ReadData1, 64'h0);
        check("edge_reset_cnt", {60'h0, WB_Count}, 64'h0);

        // counter wrap: 17 commits round-robin, x0 writes interleaved
        model_cnt = 4'd0;
        saw_wrap  = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i % 4 == 2) begin
                @(negedge clk);
                drive(1'b0, 1'b1, 5'd0, 64'hFF, 64'h0, 5'd0, 5'd0);
                exp_q.push_back({60'h0, model_cnt});
                @(negedge clk);
                drive(1'b0, 1'b0, 5'd0, '0, '0, 5'd0, 5'd0);
                #1;
                exp_v = exp_q.pop_front();
                check($sformatf("wrap_x0_%0d_cnt", i), {60'h0, WB_Count}, exp_v);
            end
            wr_rd = 5'((i % 31) + 1);
            @(negedge clk);
            drive(1'b0, 1'b1, wr_rd, 64'(i + 100), 64'h0, 5'd0, 5'd0);
            if (model_cnt == 4'd15) saw_wrap = 1'b1;
            model_cnt = model_cnt + 4'd1;
            exp_q.push_back({60'h0, model_cnt});
            @(negedge clk);
            drive(1'b0, 1'b0, 5'd0, '0, '0, wr_rd, 5'd0);
            #1;
            exp_v = exp_q.pop_front();
            check($sformatf("wrap_%0d_cnt", i), {60'h0, WB_Count}, exp_v);
            check($sformatf("wrap_%0d_data", i), ReadData1, 64'(i + 100));
        end
        check("wrap_seen", {63'h0, saw_wrap}, 64'h1);
        check("wrap_final_cnt", {60'h0, WB_Count}, 64'd1);
        RS1 = 5'd1;
        RS2 = 5'd17;
        #1;
        check("wrap_x1", ReadData1, 64'd100);
        check("wrap_x17", ReadData2, 64'd116);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
